// File: rtl/test_detector_writer_pkg.sv
// Shared types and config clamping helpers for the detector test-pattern writer.
package test_detector_writer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned CNTR_WIDTH_DEF = 32;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic logic [7:0] width_eff_f(input logic [7:0] width);
    return (width == 8'd0) ? 8'd1 : width;
  endfunction

  // Guarantees at least one all-zero cycle between consecutive pulses.
  function automatic logic [63:0] period_eff_f(input logic [63:0] period,
                                               input logic [7:0]  width_eff);
    logic [63:0] min_period;
    min_period = {56'd0, width_eff} + 64'd1;
    return (period < min_period) ? min_period : period;
  endfunction

endpackage

// File: rtl/test_detector_pulse_timer.sv
// Phase counter for one pulse period; flags the last high cycle and the last period cycle.
module test_detector_pulse_timer
  import test_detector_writer_pkg::*;
#(
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  run_i,
  input  logic [7:0]            width_i,
  input  logic [CNTR_WIDTH-1:0] period_i,
  output logic                  hi_end_o,
  output logic                  period_end_o
);

  logic [7:0]            width_q,  width_d;
  logic [CNTR_WIDTH-1:0] period_q, period_d;
  logic [CNTR_WIDTH-1:0] phase_q,  phase_d;

  assign hi_end_o     = (phase_q == CNTR_WIDTH'(width_q - 8'd1));
  assign period_end_o = (phase_q == (period_q - CNTR_WIDTH'(1)));

  always_comb begin
    width_d  = width_q;
    period_d = period_q;
    phase_d  = phase_q;
    if (start_i) begin
      width_d  = width_eff_f(width_i);
      period_d = CNTR_WIDTH'(period_eff_f(64'(period_i), width_eff_f(width_i)));
      phase_d  = '0;
    end else if (run_i) begin
      phase_d = period_end_o ? '0 : phase_q + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      width_q  <= '0;
      period_q <= '0;
      phase_q  <= '0;
    end else begin
      width_q  <= width_d;
      period_q <= period_d;
      phase_q  <= phase_d;
    end
  end

endmodule

// File: rtl/test_detector_writer.sv
// Burst generator of rectangular hit pulses on a rotating channel mask, driving det_data.
module test_detector_writer
  import test_detector_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNTR_WIDTH = CNTR_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic [7:0]            cfg_width,
  input  logic [CNTR_WIDTH-1:0] cfg_period,
  input  logic [CNTR_WIDTH-1:0] cfg_number,
  input  logic [5:0]            cfg_shift,
  input  logic                  trg,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] det_data,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] det_q, det_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [5:0]            shift_q, shift_d;
  logic [CNTR_WIDTH-1:0] number_q, number_d;
  logic [CNTR_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNTR_WIDTH-1:0] pcnt_inc;
  logic [2*DATA_WIDTH-1:0] mask_dbl;
  logic [DATA_WIDTH-1:0] mask_rot;
  logic                  start, hi_end, period_end;

  // Upper half of the doubled word shifted left is the cyclic left rotation.
  assign mask_dbl = {mask_q, mask_q} << shift_q;
  assign mask_rot = mask_dbl[2*DATA_WIDTH-1:DATA_WIDTH];
  assign pcnt_inc = pcnt_q + CNTR_WIDTH'(1);

  test_detector_pulse_timer #(
    .CNTR_WIDTH(CNTR_WIDTH)
  ) u_timer (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .start_i      (start),
    .run_i        (state_q == ST_RUN),
    .width_i      (cfg_width),
    .period_i     (cfg_period),
    .hi_end_o     (hi_end),
    .period_end_o (period_end)
  );

  always_comb begin
    state_d  = state_q;
    det_d    = det_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mask_d   = mask_q;
    shift_d  = shift_q;
    number_d = number_q;
    pcnt_d   = pcnt_q;
    start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        det_d  = '0;
        busy_d = 1'b0;
        if (trg && !stop) begin
          start    = 1'b1;
          state_d  = ST_RUN;
          mask_d   = cfg_mask;
          shift_d  = cfg_shift;
          number_d = cfg_number;
          pcnt_d   = '0;
          det_d    = cfg_mask;
          busy_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
          det_d   = '0;
          busy_d  = 1'b0;
        end else if (period_end) begin
          pcnt_d = pcnt_inc;
          if ((number_q != '0) && (pcnt_inc == number_q)) begin
            state_d = ST_IDLE;
            det_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            mask_d = mask_rot;
            det_d  = mask_rot;
          end
        end else if (hi_end) begin
          det_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      det_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      shift_q  <= '0;
      number_q <= '0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      det_q    <= det_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      shift_q  <= shift_d;
      number_q <= number_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign det_data = det_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
